// File: rtl/dispatch_slot_scheduler.sv
// Dispatch front end: hazard-checks decoded instructions against in-flight slots,
// allocates the lowest free tracking slot, and issues its index through an output register.
module dispatch_slot_scheduler #(
    parameter int CORE          = 0,
    parameter int ADDRESS_WIDTH = 5,
    parameter int STAGES        = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_rs1,
    input  logic [ADDRESS_WIDTH-1:0] in_rs2,
    input  logic [ADDRESS_WIDTH-1:0] in_rW,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [STAGES-1:0]        out_index,
    input  logic                     wb_valid,
    input  logic [STAGES-1:0]        wb_index,
    output logic                     reg_insert,
    output logic [ADDRESS_WIDTH-1:0] reg_rs1,
    output logic [ADDRESS_WIDTH-1:0] reg_rs2,
    output logic [ADDRESS_WIDTH-1:0] reg_rW,
    output logic [STAGES-1:0]        reg_indexIns,
    output logic                     reg_delete,
    output logic [STAGES-1:0]        reg_indexDel,
    output logic [STAGES:0]          occupancy,
    output logic                     full,
    output logic                     hazard
);

    logic [STAGES-1:0]        busy_q, busy_d;
    logic [ADDRESS_WIDTH-1:0] dest_q [STAGES];
    logic [ADDRESS_WIDTH-1:0] dest_d [STAGES];
    logic                     out_valid_q, out_valid_d;
    logic [STAGES-1:0]        out_index_q, out_index_d;
    logic [STAGES:0]          occ_q, occ_d;

    logic                     hazard_c;
    logic [STAGES-1:0]        alloc_idx;
    logic [STAGES-1:0]        alloc_oh;
    logic [STAGES-1:0]        retire_oh;
    logic                     retire_c;
    logic                     accept;

    // Hazard, allocation and retire qualification all look at registered state only.
    always_comb begin
        hazard_c  = 1'b0;
        alloc_idx = '0;
        alloc_oh  = '0;
        retire_oh = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (busy_q[i] && (dest_q[i] != '0)) begin
                if (((in_rs1 != '0) && (in_rs1 == dest_q[i])) ||
                    ((in_rs2 != '0) && (in_rs2 == dest_q[i])) ||
                    ((in_rW  != '0) && (in_rW  == dest_q[i]))) begin
                    hazard_c = 1'b1;
                end
            end
            if (wb_valid && busy_q[i] && (wb_index == STAGES'(i))) begin
                retire_oh[i] = 1'b1;
            end
        end
        // Walk downward so the last match left standing is the lowest free slot.
        for (int unsigned i = STAGES; i > 0; i--) begin
            if (!busy_q[i-1]) begin
                alloc_idx = STAGES'(i - 1);
            end
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            alloc_oh[i] = (alloc_idx == STAGES'(i));
        end
    end

    assign hazard       = in_valid & hazard_c;
    assign full         = (occ_q == (STAGES + 1)'(STAGES));
    assign in_ready     = ~full & ~hazard & (~out_valid_q | out_ready);
    assign accept       = in_valid & in_ready;
    assign retire_c     = |retire_oh;

    assign reg_insert   = accept;
    assign reg_indexIns = alloc_idx;
    assign reg_rs1      = in_rs1;
    assign reg_rs2      = in_rs2;
    assign reg_rW       = in_rW;
    assign reg_delete   = retire_c;
    assign reg_indexDel = wb_index;

    assign out_valid    = out_valid_q;
    assign out_index    = out_index_q;
    assign occupancy    = occ_q;

    always_comb begin
        busy_d      = busy_q;
        dest_d      = dest_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        occ_d       = occ_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (accept && alloc_oh[i]) begin
                busy_d[i] = 1'b1;
                dest_d[i] = in_rW;
            end
            if (retire_oh[i]) begin
                busy_d[i] = 1'b0;
                dest_d[i] = '0;
            end
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_index_d = alloc_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        case ({accept, retire_c})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            occ_q       <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            occ_q       <= occ_d;
            for (int unsigned i = 0; i < STAGES; i++) begin
                dest_q[i] <= dest_d[i];
            end
        end
    end

endmodule

// File: doc/dispatch_slot_scheduler.md
# dispatch_slot_scheduler

Front end of the dispatch stage. Accepts decoded instructions (rs1, rs2, rW) over a valid/ready handshake, blocks any instruction with a register hazard against in-flight work, and allocates a free tracking slot. It drives the insert/delete ports of the dispatch register storage, then issues the slot index downstream. Slots are released when writeback retires them, which caps the number of in-flight instructions at STAGES.

## Interface
- CORE, 0, core identifier; carried for instance naming only, no functional effect
- ADDRESS_WIDTH, 5, architectural register index width
- STAGES, 4, number of tracking slots; all slot-index ports are STAGES bits wide, legal values 0..STAGES-1

- clock  input  1  sole clock; all state updates on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clock
- in_valid  input  1  decoded instruction present
- in_ready  output  1  scheduler accepts this cycle
- in_rs1, in_rs2, in_rW  input  ADDRESS_WIDTH each  source and destination registers; register 0 means none
- out_valid  output  1  issued instruction present downstream
- out_ready  input  1  downstream consumes this cycle
- out_index  output  STAGES  slot index of the issued instruction
- wb_valid  input  1  writeback retiring a slot
- wb_index  input  STAGES  slot being retired
- reg_insert  output  1  storage write strobe
- reg_rs1, reg_rs2, reg_rW  output  ADDRESS_WIDTH each  storage write data, equal to in_rs1/in_rs2/in_rW
- reg_indexIns  output  STAGES  storage write slot
- reg_delete  output  1  storage clear strobe
- reg_indexDel  output  STAGES  storage clear slot
- occupancy  output  STAGES+1  count of busy slots
- full  output  1  occupancy == STAGES
- hazard  output  1  in_valid asserted and a RAW or WAW hazard exists

## Operation
- Per-slot state: busy bit and dest[ADDRESS_WIDTH], a local copy of rW.
- Hazard: in_valid, and some busy slot has dest != 0 matching a nonzero in_rs1, a nonzero in_rs2, or a nonzero in_rW.
- Hazard, full and allocation are evaluated from registered state only. Writeback in the same cycle does not bypass into them.
- in_ready = ~full & ~hazard & (~out_valid | out_ready). It is combinational and must not depend on in_valid, except through hazard.
- accept = in_valid & in_ready.
- Allocation: the lowest-numbered non-busy slot.
- reg_insert = accept, combinational. reg_indexIns is the allocated slot; reg_rs1/reg_rs2/reg_rW pass the input fields through.
- On accept: the slot's busy bit is set and dest <= in_rW.
- Output register: on accept, out_valid <= 1 and out_index <= the allocated slot. Otherwise, when out_ready is high, out_valid <= 0. Holding out_valid without out_ready keeps out_index stable.
- Retire: when wb_valid is high and slot wb_index is busy, that slot's busy bit clears and dest clears to 0.
  - reg_delete = wb_valid & busy[wb_index], combinational.
  - reg_indexDel = wb_index.
- Retire of a non-busy slot, or wb_index >= STAGES, is ignored: no reg_delete and no state change.
- occupancy: +1 on accept, -1 on a valid retire. Both in the same cycle leave it unchanged.
- Reset: every slot not busy, every dest = 0, out_valid = 0, out_index = 0, occupancy = 0.
  - Combinational outputs then follow: in_ready = 1, full = 0, hazard = 0 (given in_valid low), reg_insert = 0, reg_delete = 0.
  - Reset overrides any accept or retire in the same cycle. An instruction in flight in the output register is dropped.

## Timing
- Accept in cycle N: storage written at the N edge. out_valid and out_index are visible in N+1. occupancy updates in N+1.
- Retire in cycle N: the slot is free and its hazard is cleared from N+1. A dependent instruction waiting in N can accept no earlier than N+1.
- Full plus retire in cycle N: in_ready stays 0 in N and the freed slot becomes allocatable in N+1.
- Back-to-back issue: one instruction per cycle while out_ready = 1, no hazards and a free slot exists.
- Throughput limit: STAGES in-flight instructions. Issuing the (STAGES+1)th requires a retire.

## Test plan
- Reset then in_valid with rs1=1, rs2=2, rW=3 -> in_ready=1, reg_insert=1, reg_indexIns=0. Next cycle: out_valid=1, out_index=0, occupancy=1.
- RAW: issue rW=5, then rs1=5 -> hazard=1 and in_ready=0 until wb_valid with wb_index=0. reg_delete=1 and reg_indexDel=0 that cycle; the dependent instruction accepts the following cycle into slot 0.
- Fill: four independent instructions (rW=1..4, rs=0) with out_ready=1 -> slots 0,1,2,3 and full=1. The fifth stalls. Retire of slot 2 -> the fifth gets slot 2 one cycle later.
- Register 0 exemption: rW=0 in flight, next instruction rs1=0, rW=0 -> no hazard, accepted immediately.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_index held. Raising out_ready with in_valid present -> accept in the same cycle.
- Spurious or reset cases:
  - wb_valid on a non-busy slot -> reg_delete=0, occupancy unchanged.
  - reset asserted with 3 slots busy and out_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1.
